// File: rtl/nes_ctrl_pkg.sv
// Shared front-panel definitions: controller state encoding and select-button constants.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package nes_ctrl_pkg;

    localparam int NUM_SEL = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_FIRE    = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_WAIT_HI = 3'd4
    } state_t;

    // Lowest-numbered asserted select line wins when several are held together.
    function automatic logic [1:0] lowest_sel(input logic [NUM_SEL-1:0] sel);
        logic [1:0] code;
        code = '0;
        for (int i = NUM_SEL - 1; i >= 0; i--) begin
            if (sel[i]) begin
                code = 2'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw active-low button: 2-flop synchronizer followed by a saturating stability counter.
// Latency: 2 sync clocks plus 2^DB_BITS consecutive clocks of a changed level before stable_n follows.
// Backpressure: none; the input is free-running and the output is a level.
module btn_debounce #(
    parameter int DB_BITS = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_n,
    output logic stable_n
);

    logic               sync_1;
    logic               sync_2;
    logic [DB_BITS-1:0] db_cnt;

    // Bring the asynchronous button into the clock domain; released (1) out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= raw_n;
            sync_2 <= sync_1;
        end
    end

    // Count clocks the synced level disagrees with the accepted level; accept it once the counter saturates.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_n <= 1'b1;
            db_cnt   <= '0;
        end else if (sync_2 == stable_n) begin
            db_cnt   <= '0;
        end else if (db_cnt == '1) begin
            stable_n <= sync_2;
            db_cnt   <= '0;
        end else begin
            db_cnt   <= db_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rom_select.sv
// Front-panel ROM selector: debounced select/shift buttons choose a slot and request a flash reload.
// Latency: reload/index update one clock after the ARMED->FIRE decision; busy is decoded from state.
// Backpressure: button activity is ignored while a reload is in flight (FIRE/WAIT_LO/WAIT_HI).
module rom_select
    import nes_ctrl_pkg::*;
#(
    parameter int DB_BITS      = 16,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] btn_n,
    input  logic       load_done,
    output logic [3:0] index,
    output logic       reload,
    output logic       busy
);

    localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

    logic [4:0] stable_n;
    logic [4:0] pressed;
    logic       sel_any;
    logic       fire_go;
    state_t     state;
    state_t     state_nxt;
    logic [2:0] cand;
    logic [7:0] tmo_cnt;

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(
            .DB_BITS (DB_BITS)
        ) u_btn_debounce (
            .clock    (clock),
            .reset    (reset),
            .raw_n    (btn_n[i]),
            .stable_n (stable_n[i])
        );
    end

    assign pressed = ~stable_n;
    assign sel_any = |pressed[NUM_SEL-1:0];
    assign fire_go = (state == ST_ARMED) && (state_nxt == ST_FIRE);

    // Next-state: arm on any select press, fire on full release, then wait for the loader handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (sel_any) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!sel_any) begin
                    state_nxt = ST_FIRE;
                end
            end
            ST_FIRE: begin
                state_nxt = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!load_done) begin
                    state_nxt = ST_WAIT_HI;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_HI: begin
                if (load_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Track the most recent select/shift combination while armed; hold it once all selects release.
    always_ff @(posedge clock) begin
        if (reset) begin
            cand <= '0;
        end else if ((state == ST_ARMED) && sel_any) begin
            cand <= {pressed[4], lowest_sel(pressed[NUM_SEL-1:0])};
        end
    end

    // Timeout for load_done to drop; restarts from zero each time WAIT_LO is entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if ((state == ST_WAIT_LO) && (state_nxt == ST_WAIT_LO)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Registered reload pulse and slot index, both presented during the FIRE clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            reload <= 1'b0;
            index  <= '0;
        end else begin
            reload <= fire_go;
            if (fire_go) begin
                index <= {1'b0, cand};
            end
        end
    end

    assign busy = (state == ST_FIRE) || (state == ST_WAIT_LO) || (state == ST_WAIT_HI);

endmodule
